// File: rtl/ann_pkg.sv
// Shared definitions for the neuron MAC block: the controller state
// encoding and the default widths used as parameter defaults.
package ann_pkg;

    localparam int DATA_W  = 8;   // activation, weight and output width
    localparam int ACC_W   = 20;  // accumulator and bias width
    localparam int N_TAPS  = 4;   // products summed per output
    localparam int FRAC_SH = 4;   // fixed-point shift before saturation

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        BIAS  = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/neuron_act.sv
// Output stage of the neuron: arithmetic shift of the accumulator,
// saturation to the signed output range and an optional ReLU.
// Build option: define NEURON_MAC_RELU_EN to clamp negative results to 0.
module neuron_act #(
    parameter int DATA_W  = ann_pkg::DATA_W,
    parameter int ACC_W   = ann_pkg::ACC_W,
    parameter int FRAC_SH = ann_pkg::FRAC_SH
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] act
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] sat_val;

    // Rescale the accumulator and clamp it into the output word range.
    always_comb begin
        shifted = acc >>> FRAC_SH;
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_val = shifted[DATA_W-1:0];
        end
    end

    // Optional rectification of the saturated value.
    always_comb begin
`ifdef NEURON_MAC_RELU_EN
        act = sat_val[DATA_W-1] ? '0 : sat_val;
`else
        act = sat_val;
`endif
    end

endmodule

// File: rtl/neuron_mac.sv
// Single neuron: accumulates N_TAPS signed x*w products, adds a bias,
// then presents the shifted/saturated result on a valid/ready output.
// Build option: NEURON_MAC_RELU_EN enables ReLU in the output stage.
module neuron_mac #(
    parameter int DATA_W  = ann_pkg::DATA_W,
    parameter int ACC_W   = ann_pkg::ACC_W,
    parameter int N_TAPS  = ann_pkg::N_TAPS,
    parameter int FRAC_SH = ann_pkg::FRAC_SH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_w,
    input  logic signed [ACC_W-1:0]  bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     busy
);

    import ann_pkg::*;

    // A single-tap build still needs a 1-bit counter to stay legal.
    localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

    state_t                   state_reg, state_next;
    logic [CNT_W-1:0]         tap_reg, tap_next;
    logic signed [ACC_W-1:0]  acc_reg, acc_next;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;

    // Full-precision product, sign-extended into the accumulator width.
    assign prod     = in_x * in_w;
    assign prod_ext = ACC_W'(prod);

    // State, tap counter and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ACCUM;
            tap_reg   <= '0;
            acc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tap_reg   <= tap_next;
            acc_reg   <= acc_next;
        end
    end

    // Next-state logic: accumulate taps, add bias for one cycle, then
    // hold the result until the consumer takes it.
    always_comb begin
        state_next = state_reg;
        tap_next   = tap_reg;
        acc_next   = acc_reg;
        case (state_reg)
            ACCUM: begin
                if (in_valid) begin
                    acc_next = (tap_reg == '0) ? prod_ext : acc_reg + prod_ext;
                    if (tap_reg == LAST_TAP) begin
                        tap_next   = '0;
                        state_next = BIAS;
                    end else begin
                        tap_next = tap_reg + CNT_W'(1);
                    end
                end
            end
            BIAS: begin
                acc_next   = acc_reg + bias;
                state_next = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // Handshake and status flags decoded from the current state.
    always_comb begin
        in_ready  = (state_reg == ACCUM);
        out_valid = (state_reg == OUT);
        busy      = (state_reg != ACCUM) || (tap_reg != '0);
    end

    neuron_act #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .FRAC_SH (FRAC_SH)
    ) u_act (
        .acc (acc_reg),
        .act (out_data)
    );

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: the stimulus process pushes the
// hand-computed result of every group; a negedge monitor pops and
// compares on each output handshake and checks reset, hold, latency
// and ready behaviour.
module tb_neuron_mac;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_x;
    logic signed [7:0]  in_w;
    logic signed [19:0] bias;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_data;
    logic               busy;

    logic signed [7:0] exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    bit  done = 1'b0;
    bit  final_done = 1'b0;

    // monitor state
    bit  rst_d = 1'b0;
    bit  hold_d = 1'b0;
    bit  hs_d = 1'b0;
    logic signed [7:0] data_d = '0;
    int  taps_m = 0;
    int  lat_m = 0;

    always #5 clk = ~clk;

    neuron_mac #(
        .DATA_W  (8),
        .ACC_W   (20),
        .N_TAPS  (4),
        .FRAC_SH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic signed [7:0] exp_val(input int v);
`ifdef NEURON_MAC_RELU_EN
        return (v < 0) ? 8'sd0 : 8'(v);
`else
        return 8'(v);
`endif
    endfunction

    task automatic check(input string name, input int got, input int expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        logic signed [7:0] e;
        if (rst_d) begin
            check("reset_out_valid", int'(out_valid), 0);
            check("reset_out_data", int'(out_data), 0);
            check("reset_in_ready", int'(in_ready), 1);
            check("reset_busy", int'(busy), 0);
            taps_m = 0;
            lat_m  = 0;
            hold_d = 1'b0;
            hs_d   = 1'b0;
        end else begin
            if (hold_d) begin
                check("hold_out_valid", int'(out_valid), 1);
                check("hold_out_data", int'(out_data), int'(data_d));
            end
            if (hs_d) begin
                check("post_handshake_in_ready", int'(in_ready), 1);
                check("post_handshake_out_valid", int'(out_valid), 0);
            end
            if (lat_m == 1) begin
                check("latency_bias_cycle_out_valid", int'(out_valid), 0);
                lat_m = 2;
            end else if (lat_m == 2) begin
                check("latency_out_cycle_out_valid", int'(out_valid), 1);
                lat_m = 0;
            end
            if (taps_m != 0) check("busy_mid_group", int'(busy), 1);
        end
        if (out_valid === 1'b1) check("in_ready_during_out", int'(in_ready), 0);

        hold_d = !rst && (out_valid === 1'b1) && !out_ready;
        hs_d   = !rst && (out_valid === 1'b1) && out_ready;
        data_d = out_data;
        if (!rst && in_valid && (in_ready === 1'b1)) begin
            if (taps_m == 3) begin
                taps_m = 0;
                lat_m  = 1;
            end else begin
                taps_m++;
            end
        end
        if (!rst && (out_valid === 1'b1) && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got %0d, expected no output", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", int'(out_data), int'(e));
                $display("output %0d (expected %0d)", out_data, e);
            end
        end
        if (done && !final_done) begin
            check("scoreboard_drained", exp_q.size(), 0);
            final_done = 1'b1;
        end
        rst_d = rst;
    end

    task automatic tap(input logic signed [7:0] x, input logic signed [7:0] w);
        in_x = x;
        in_w = w;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x = 8'sh5A;   // garbage while idle: must not be accumulated
        in_w = 8'sh5A;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
    endtask

    task automatic run_group(input logic signed [7:0] x, input logic signed [7:0] w,
                             input logic signed [19:0] b, input bit gaps,
                             input int hold, input int expv);
        bias = b;
        exp_q.push_back(exp_val(expv));
        if (hold > 0) out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tap(x, w);
            if (gaps) begin
                @(posedge clk);
                #1;
            end
        end
        if (hold > 0) begin
            wait_out_valid();
            repeat (hold) @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        wait_drain();
        bias = '0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_x = '0;
        in_w = '0;
        bias = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        //        x      w     bias    gaps hold expected (before ReLU)
        run_group(8'sd16, 8'sd1, 20'sd0, 1'b0, 0, 4);      // basic
        run_group(8'sd127, 8'sd127, 20'sd0, 1'b0, 0, 127); // acc 64516 saturates
        run_group(-8'sd16, 8'sd16, 20'sd0, 1'b0, 0, -64);  // acc -1024
        run_group(-8'sd128, 8'sd127, 20'sd0, 1'b0, 0, -128); // negative saturation
        run_group(-8'sd128, -8'sd128, 20'sd0, 1'b0, 0, 127); // acc 65536
        run_group(-8'sd3, 8'sd7, 20'sd0, 1'b0, 0, -6);     // -84 >>> 4 rounds down
        run_group(8'sd1, 8'sd1, -20'sd100, 1'b0, 0, -6);   // 4 - 100 = -96
        run_group(8'sd0, 8'sd0, 20'sd32, 1'b1, 0, 2);      // bias only, with gaps
        run_group(8'sd16, 8'sd2, 20'sd0, 1'b1, 0, 8);      // gaps hold acc
        run_group(8'sd16, 8'sd3, 20'sd0, 1'b0, 5, 12);     // backpressure 5 cycles

        // reset after two taps: those taps must leave no residue
        tap(8'sd100, 8'sd100);
        tap(8'sd100, 8'sd100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_group(8'sd16, 8'sd1, 20'sd0, 1'b0, 0, 4);

        // reset while a result is waiting in OUT: that result is dropped
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tap(8'sd50, 8'sd50);
        wait_out_valid();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        run_group(8'sd5, 8'sd8, 20'sd0, 1'b0, 0, 10);

        done = 1'b1;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
